l_fifo_reader: RTL and testbench

- Read-side drain engine for the 8-bit synchronous L-channel FIFO (depth 2048, almost_empty threshold 4).
- Pops bytes from the FIFO read port, which has 1-cycle read latency and no output register.
- Packs the bytes little-endian into BYTES_PER_WORD-byte words and presents them on a valid/ready stream to the downstream consumer.
- Waits for a prime level after enable and counts underrun cycles.

---
 rtl/l_fifo_reader.sv | 101 ++++++++++
 tb/tb_l_fifo_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l_fifo_reader.sv
// Drains an 8-bit synchronous FIFO with a 1-cycle read latency and packs the bytes
// little-endian into words presented on a valid/ready stream. It also counts starved cycles.
module l_fifo_reader #(
   parameter int DATA_WIDTH     = 8,
   parameter int BYTES_PER_WORD = 2,
   parameter int PRIME_EN       = 1,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   output logic                                 fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]                fifo_rd_data,
   input  logic                                 fifo_rd_empty,
   input  logic                                 fifo_almost_empty,
   output logic                                 m_valid,
   output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] m_data,
   input  logic                                 m_ready,
   output logic [CNT_WIDTH-1:0]                 underrun_cnt,
   output logic                                 running
);

   localparam int WW = DATA_WIDTH * BYTES_PER_WORD;
   localparam int HW = $clog2(BYTES_PER_WORD + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   bytes_held;
   logic            inflight;
   logic [WW-1:0]   asm_q, asm_fill;
   logic            word_done, xfer;
   logic [4:0]      occ;

   // Stream handshake: a word moves when m_valid and m_ready are both high at a clk edge.
   // While m_valid is high and m_ready is low, m_data is held stable.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = (PRIME_EN != 0) ? PRIME : RUN;
         PRIME:   if (!en) state_d = IDLE;
                  else if (!fifo_almost_empty) state_d = RUN;
         RUN:     if (!en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A byte landing in the last free slot completes the word in the same cycle.
   // This lets a full word leave every BYTES_PER_WORD cycles without a bubble.
   always_comb begin
      asm_fill = asm_q;
      if (inflight) begin
         for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (HW'(i) == bytes_held) asm_fill[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
         end
      end
      word_done  = (bytes_held == HW'(BYTES_PER_WORD)) ||
                   (inflight && (bytes_held == HW'(BYTES_PER_WORD - 1)));
      xfer       = word_done && (!m_valid || m_ready);
      occ        = 5'(bytes_held) + 5'(inflight) - (xfer ? 5'(BYTES_PER_WORD) : 5'd0);
      fifo_rd_en = (state_q == RUN) && en && !fifo_rd_empty && (occ < 5'(BYTES_PER_WORD));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bytes_held   <= '0;
         inflight     <= 1'b0;
         asm_q        <= '0;
         m_valid      <= 1'b0;
         m_data       <= '0;
         underrun_cnt <= '0;
      end else begin
         state_q  <= state_d;
         inflight <= fifo_rd_en;
         if (xfer) begin
            m_data  <= asm_fill;
            m_valid <= 1'b1;
            // A word full from earlier cycles leaves slot 0 free for a byte landing now.
            if (inflight && (bytes_held == HW'(BYTES_PER_WORD))) begin
               asm_q[DATA_WIDTH-1:0] <= fifo_rd_data;
               bytes_held            <= HW'(1);
            end else begin
               bytes_held <= '0;
            end
         end else begin
            if (m_valid && m_ready) m_valid <= 1'b0;
            if (inflight) begin
               asm_q      <= asm_fill;
               bytes_held <= bytes_held + 1'b1;
            end
         end
         if ((state_q == RUN) && m_ready && !m_valid && fifo_rd_empty && !inflight &&
             (underrun_cnt != '1))
            underrun_cnt <= underrun_cnt + 1'b1;
      end
   end

   assign running = (state_q == RUN);

endmodule

// File: tb/tb_l_fifo_reader.sv
// Bench for l_fifo_reader: a behavioural FIFO, an expected-word scoreboard built from the pushed
// byte stream, and an independent monitor that checks handshakes, hold behaviour and underruns.
module tb_l_fifo_reader;

   localparam int BPW = 2;
   localparam int W   = 8 * BPW;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          en = 1'b0, m_ready = 1'b0;
   logic          fifo_rd_en, fifo_rd_empty, fifo_almost_empty;
   logic [7:0]    fifo_rd_data = '0;
   logic          m_valid, running;
   logic [W-1:0]  m_data;
   logic [15:0]   underrun_cnt;

   l_fifo_reader #(.DATA_WIDTH(8), .BYTES_PER_WORD(BPW), .PRIME_EN(1), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst(rst), .en(en),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_empty(fifo_rd_empty), .fifo_almost_empty(fifo_almost_empty),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .underrun_cnt(underrun_cnt), .running(running)
   );

   // FIFO model and scoreboard state
   logic [7:0]   fq[$], wr_q[$], byte_q[$];
   logic [W-1:0] exp_q[$];
   int           fifo_cnt = 0;
   bit           inflight_m = 1'b0;
   int           flush_req_n = 0, flush_done_n = 0;
   int           checks = 0, errors = 0;
   int           exp_un = 0;
   bit           prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;

   assign fifo_rd_empty     = (fifo_cnt == 0);
   assign fifo_almost_empty = (fifo_cnt <= 4);

   always @(posedge clk) begin
      inflight_m = 1'b0;
      if (fifo_rd_en === 1'b1 && fq.size() > 0) begin
         fifo_rd_data <= fq.pop_front();
         inflight_m = 1'b1;
      end
      if (flush_req_n != flush_done_n) begin
         fq.delete();
         flush_done_n = flush_req_n;
      end
      while (wr_q.size() > 0) fq.push_back(wr_q.pop_front());
      fifo_cnt <= fq.size();
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
      end
   endtask

   // driver tasks
   task automatic push_byte(input logic [7:0] b);
      logic [W-1:0] w;
      wr_q.push_back(b);
      byte_q.push_back(b);
      if (byte_q.size() == BPW) begin
         w = '0;
         for (int i = 0; i < BPW; i++) w[i*8 +: 8] = byte_q.pop_front();
         exp_q.push_back(w);
      end
   endtask

   task automatic wait_drain(input int budget, input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d words still pending after %0d cycles, expected 0", nm, exp_q.size(), n);
      end
   endtask

   // monitor: words, hold stability, read-while-empty and the underrun reference count
   always @(negedge clk) begin
      if (rst) begin
         exp_un     = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(prev_data));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL word: unexpected word 0x%0h, expected none", m_data);
            end else begin
               chk("word", 32'(m_data), 32'(exp_q.pop_front()));
            end
         end
         if (fifo_rd_en) chk("rd_when_empty", 32'(fifo_rd_empty), 32'd0);
         chk("underrun_cnt", 32'(underrun_cnt), 32'(exp_un));
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         if (running && m_ready && !m_valid && fifo_rd_empty && !inflight_m && exp_un < 65535)
            exp_un++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int reads, run, maxrun, start, found, n;

      // reset with en held high
      rst = 1'b1; en = 1'b1; m_ready = 1'b0;
      push_byte(8'h11); push_byte(8'h22);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_underrun", 32'(underrun_cnt), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      rst = 1'b0;
      reads = 0;
      repeat (5) begin
         @(negedge clk);
         if (fifo_rd_en) reads++;
      end
      chk("prime_no_reads", 32'(reads), 32'd0);
      chk("prime_state", 32'(u_dut.state_q), 32'd1);

      // prime and pack: 6 bytes, sustained reads
      @(posedge clk); #1;
      m_ready = 1'b1;
      push_byte(8'h33); push_byte(8'h44); push_byte(8'h55); push_byte(8'h66);
      reads = 0; run = 0; maxrun = 0;
      repeat (20) begin
         @(negedge clk);
         if (fifo_rd_en) begin
            reads++; run++;
            if (run > maxrun) maxrun = run;
         end else run = 0;
      end
      wait_drain(40, "pack_drain");
      chk("pack_reads", 32'(reads), 32'd6);
      chk("pack_consecutive", 32'(maxrun), 32'd6);

      // backpressure
      @(posedge clk); #1;
      m_ready = 1'b0;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      push_byte(8'h44); push_byte(8'h55); push_byte(8'h66);
      reads = 0;
      repeat (10) begin
         @(negedge clk);
         if (fifo_rd_en) reads++;
      end
      chk("bp_reads", 32'(reads), 32'd4);
      chk("bp_valid", 32'(m_valid), 32'd1);
      chk("bp_data", 32'(m_data), 32'h2211);
      @(posedge clk); #1;
      m_ready = 1'b1;
      wait_drain(40, "bp_drain");

      // underrun: empty FIFO, RUN, m_ready high
      found = 0; n = 0;
      while (!found && n < 20) begin
         @(negedge clk);
         n++;
         if (!m_valid && fifo_rd_empty && !inflight_m && running) found = 1;
      end
      chk("underrun_quiet", 32'(found), 32'd1);
      @(posedge clk); #1;
      start = exp_un;
      reads = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (fifo_rd_en) reads++;
      end
      chk("underrun_20", 32'(underrun_cnt), 32'(start + 20));
      chk("underrun_no_reads", 32'(reads), 32'd0);

      // disable right after a read; the byte must be kept
      @(posedge clk); #1;
      push_byte(8'hAA);
      found = 0; n = 0;
      while (!found && n < 10) begin
         @(negedge clk);
         n++;
         if (fifo_rd_en) found = 1;
      end
      chk("dis_read_seen", 32'(found), 32'd1);
      @(posedge clk); #1;
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("dis_running", 32'(running), 32'd0);
      chk("dis_bytes_held", 32'(u_dut.bytes_held), 32'd1);
      chk("dis_m_valid", 32'(m_valid), 32'd0);
      push_byte(8'hBB); push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
      en = 1'b1;
      wait_drain(60, "reen_drain");

      // reset mid-operation with a word pending and a read in flight
      @(posedge clk); #1;
      m_ready = 1'b0;
      push_byte(8'hD1); push_byte(8'hD2); push_byte(8'hD3); push_byte(8'hD4);
      found = 0; n = 0;
      while (!found && n < 20) begin
         @(negedge clk);
         n++;
         if (m_valid && u_dut.inflight) found = 1;
      end
      chk("midrst_setup", 32'(found), 32'd1);
      rst = 1'b1;
      flush_req_n++;
      wr_q.delete(); exp_q.delete(); byte_q.delete();
      @(posedge clk); #1;
      chk("midrst_m_valid", 32'(m_valid), 32'd0);
      chk("midrst_bytes_held", 32'(u_dut.bytes_held), 32'd0);
      chk("midrst_underrun", 32'(underrun_cnt), 32'd0);
      chk("midrst_inflight", 32'(u_dut.inflight), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b0; m_ready = 1'b1;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_valid) n++;
      end
      chk("midrst_no_output", 32'(n), 32'd0);

      // randomized traffic with random backpressure and enable drops
      @(posedge clk); #1;
      en = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 99) < 40) push_byte(8'($urandom_range(0, 255)));
         m_ready = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 99) < 3) en = ~en;
      end
      en = 1'b1; m_ready = 1'b1;
      n = 6 + (byte_q.size() % BPW);
      for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)));
      wait_drain(1000, "random_drain");

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
